// File: rtl/pid_sched.sv
// Time-multiplexing scheduler for a shared ctrlpid_v core: steps the channel address in
// lockstep with the core's 10-state cycle, double-buffers per-channel gains, captures outputs.
module pid_sched #(
    parameter int aw  = 1,
    parameter int ew  = 24,
    parameter int ow  = 12,
    parameter int cw  = 6,
    parameter int KP0 = 0,
    parameter int KI0 = 0,
    parameter int KD0 = 0,
    localparam int an = 1 << aw
) (
    input  logic                clk_pid,
    input  logic                reset,
    input  logic [an*ew-1:0]    err_in,
    input  logic [an-1:0]       ch_en,
    input  logic                cfg_we,
    input  logic [aw-1:0]       cfg_ch,
    input  logic [1:0]          cfg_sel,
    input  logic [cw-1:0]       cfg_data,
    output logic [aw-1:0]       pid_a,
    output logic [ew-1:0]       pid_error,
    output logic [cw-1:0]       pid_kp,
    output logic [cw-1:0]       pid_ki,
    output logic [cw-1:0]       pid_kd,
    input  logic [ow-1:0]       pid_m_k,
    output logic [an*ow-1:0]    m_out,
    output logic                upd,
    output logic [aw-1:0]       upd_ch,
    output logic                frame_done
);

    // ph    | meaning
    // 0     | first cycle after reset, core in its idle state
    // 1..10 | core states E0..E9 for channel ch; m_k is valid on the ph=10 edge
    localparam logic [3:0] PH_IDLE = 4'd0;
    localparam logic [3:0] PH_LAST = 4'd10;

    localparam logic [2:0][cw-1:0] GAIN_RST = {cw'(KD0), cw'(KI0), cw'(KP0)};

    logic [3:0]                  ph_q, ph_d;
    logic [aw-1:0]               ch_q, ch_d;
    logic                        slot_end;
    logic                        load_act;
    logic [2:0][an-1:0][cw-1:0]  shd_q;
    logic [2:0][an-1:0][cw-1:0]  act_q;
    logic [an-1:0][ow-1:0]       m_q;
    logic [an-1:0][ew-1:0]       err_v;
    logic                        upd_q;
    logic [aw-1:0]               upd_ch_q;
    logic                        frame_done_q;

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            ph_q <= PH_IDLE;
        end else begin
            ph_q <= ph_d;
        end
    end

    // Unreachable encodings fall back to idle so the pair can resync after a glitch.
    always_comb begin
        ph_d = PH_IDLE;
        if (ph_q == PH_IDLE || ph_q == PH_LAST) begin
            ph_d = 4'd1;
        end else if (ph_q < PH_LAST) begin
            ph_d = ph_q + 4'd1;
        end
    end

    always_comb begin
        slot_end = (ph_q == PH_LAST);
        load_act = slot_end || (ph_q == PH_IDLE);
        ch_d     = slot_end ? ch_q + 1'b1 : ch_q;
    end

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            ch_q         <= '0;
            m_q          <= '0;
            upd_q        <= 1'b0;
            upd_ch_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ch_q         <= ch_d;
            upd_q        <= slot_end;
            frame_done_q <= slot_end && (&ch_q);
            if (slot_end) begin
                m_q[ch_q] <= ch_en[ch_q] ? pid_m_k : '0;
                upd_ch_q  <= ch_q;
            end
        end
    end

    // Active gains load only when a slot begins; a write landing on that same edge is forwarded.
    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            for (int f = 0; f < 3; f++) begin
                for (int n = 0; n < an; n++) begin
                    shd_q[f][n] <= GAIN_RST[f];
                    act_q[f][n] <= GAIN_RST[f];
                end
            end
        end else begin
            for (int f = 0; f < 3; f++) begin
                if (cfg_we && cfg_sel == 2'(f)) begin
                    shd_q[f][cfg_ch] <= cfg_data;
                end
                if (load_act) begin
                    act_q[f][ch_d] <= (cfg_we && cfg_sel == 2'(f) && cfg_ch == ch_d)
                                      ? cfg_data : shd_q[f][ch_d];
                end
            end
        end
    end

    assign err_v      = err_in;
    assign pid_a      = ch_q;
    assign pid_error  = ch_en[ch_q] ? err_v[ch_q] : '0;
    assign pid_kp     = act_q[0][ch_q];
    assign pid_ki     = act_q[1][ch_q];
    assign pid_kd     = act_q[2][ch_q];
    assign m_out      = m_q;
    assign upd        = upd_q;
    assign upd_ch     = upd_ch_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pid_sched.sv
// Directed bench for pid_sched (two channels) with a slot-level reference model
// checked every cycle, plus literal expectations from the scheduling scenarios.
module tb_pid_sched;

    localparam int AW  = 1;
    localparam int AN  = 2;
    localparam int EW  = 24;
    localparam int OW  = 12;
    localparam int CW  = 6;
    localparam int KP0 = 0;
    localparam int KI0 = 2;
    localparam int KD0 = 1;

    logic              clk_pid = 1'b0;
    logic              reset   = 1'b1;
    logic [AN*EW-1:0]  err_in;
    logic [AN-1:0]     ch_en;
    logic              cfg_we;
    logic [AW-1:0]     cfg_ch;
    logic [1:0]        cfg_sel;
    logic [CW-1:0]     cfg_data;
    logic [AW-1:0]     pid_a;
    logic [EW-1:0]     pid_error;
    logic [CW-1:0]     pid_kp, pid_ki, pid_kd;
    logic [OW-1:0]     pid_m_k;
    logic [AN*OW-1:0]  m_out;
    logic              upd;
    logic [AW-1:0]     upd_ch;
    logic              frame_done;

    always #5 clk_pid = ~clk_pid;

    pid_sched #(
        .aw(AW), .ew(EW), .ow(OW), .cw(CW), .KP0(KP0), .KI0(KI0), .KD0(KD0)
    ) dut (
        .clk_pid(clk_pid), .reset(reset), .err_in(err_in), .ch_en(ch_en),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .pid_a(pid_a), .pid_error(pid_error), .pid_kp(pid_kp), .pid_ki(pid_ki),
        .pid_kd(pid_kd), .pid_m_k(pid_m_k), .m_out(m_out), .upd(upd),
        .upd_ch(upd_ch), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: n counts clock edges since reset release; slots are 10 edges long
    // with the first one stretched by the idle cycle.
    int             n;
    int             mp, mc;
    logic [CW-1:0]  shd [3][AN];
    logic [CW-1:0]  act [3][AN];
    logic [OW-1:0]  mexp [AN];
    logic           upd_e, fd_e;
    logic [AW-1:0]  updch_e;
    logic [AN*OW-1:0] mpack;
    logic [EW-1:0]  err_e;
    bit             chk_on = 1'b0;

    function automatic int phase_of(input int k);
        return (k == 0) ? 0 : ((k - 1) % 10) + 1;
    endfunction

    function automatic int chan_of(input int k);
        return (k == 0) ? 0 : ((k - 1) / 10) % AN;
    endfunction

    function automatic logic [CW-1:0] rst_gain(input int f);
        return (f == 0) ? CW'(KP0) : (f == 1) ? CW'(KI0) : CW'(KD0);
    endfunction

    always @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            n = 0;
            for (int f = 0; f < 3; f++)
                for (int c = 0; c < AN; c++) begin
                    shd[f][c] = rst_gain(f);
                    act[f][c] = rst_gain(f);
                end
            for (int c = 0; c < AN; c++) mexp[c] = '0;
            upd_e   = 1'b0;
            fd_e    = 1'b0;
            updch_e = '0;
        end else begin
            mp = phase_of(n);
            mc = chan_of(n);
            upd_e = (mp == 10);
            fd_e  = (mp == 10) && (mc == AN - 1);
            if (mp == 10) begin
                mexp[mc] = ch_en[mc] ? pid_m_k : '0;
                updch_e  = AW'(mc);
            end
            if (cfg_we && cfg_sel != 2'd3) shd[cfg_sel][cfg_ch] = cfg_data;
            n++;
            if (phase_of(n) == 1)
                for (int f = 0; f < 3; f++) act[f][chan_of(n)] = shd[f][chan_of(n)];
        end
    end

    always @(negedge clk_pid) begin
        if (!reset && chk_on) begin
            mc = chan_of(n);
            for (int c = 0; c < AN; c++) mpack[c*OW +: OW] = mexp[c];
            err_e = ch_en[mc] ? err_in[mc*EW +: EW] : '0;
            chk("model_pid_a", pid_a, mc);
            chk("model_pid_error", pid_error, err_e);
            chk("model_pid_kp", pid_kp, act[0][mc]);
            chk("model_pid_ki", pid_ki, act[1][mc]);
            chk("model_pid_kd", pid_kd, act[2][mc]);
            chk("model_m_out", m_out, mpack);
            chk("model_upd", upd, upd_e);
            chk("model_frame_done", frame_done, fd_e);
            if (upd_e) chk("model_upd_ch", upd_ch, updch_e);
        end
    end

    task automatic tick();
        @(posedge clk_pid);
        #1;
        pid_m_k = OW'(n * 37 + 5);
    endtask

    task automatic wait_state(input int c, input int p);
        for (int k = 0; k < 60 && !(chan_of(n) == c && phase_of(n) == p); k++) tick();
        chk("wait_state_reached", (chan_of(n) == c && phase_of(n) == p), 1);
    endtask

    task automatic write_gain(input int c, input int sel, input logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_ch = AW'(c); cfg_sel = 2'(sel); cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Must be entered at posedge+1 with reset high.
    task automatic release_seq();
        reset  = 1'b0;
        chk_on = 1'b1;
        for (int j = 0; j <= 30; j++) begin
            chk("rel_pid_a", pid_a, (j >= 11 && j <= 20) ? 1 : 0);
            chk("rel_upd", upd, (j == 11 || j == 21) ? 1 : 0);
            chk("rel_frame_done", frame_done, (j == 21) ? 1 : 0);
            if (j == 11) chk("rel_upd_ch0", upd_ch, 0);
            if (j == 21) chk("rel_upd_ch1", upd_ch, 1);
            if (j == 0) begin
                chk("rel_m_out_zero", m_out, 0);
                chk("rel_kd_reset", pid_kd, CW'(KD0));
                chk("rel_ki_reset", pid_ki, CW'(KI0));
            end
            tick();
        end
    endtask

    logic [OW-1:0] old_m0;

    initial begin
        err_in   = {24'd500, 24'hFFFF38};
        ch_en    = 2'b11;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_sel  = '0;
        cfg_data = '0;
        pid_m_k  = '0;
        repeat (3) @(posedge clk_pid);
        #1;
        release_seq();

        // Gain shadowing: a mid-slot write waits for the channel's next slot.
        wait_state(1, 4);
        write_gain(1, 0, 6'd3);
        for (int k = 0; k < 10 && phase_of(n) != 1; k++) begin
            chk("kp_hold_in_slot", pid_kp, 0);
            tick();
        end
        wait_state(1, 1);
        for (int k = 0; k < 10; k++) begin
            chk("kp_next_slot", pid_kp, 3);
            tick();
        end

        // Write on the entry edge is forwarded; cfg_sel=3 is ignored.
        wait_state(0, 10);
        write_gain(1, 0, 6'h3C);
        chk("kp_forward", pid_kp, 6'h3C);
        chk("kp_forward_ch", pid_a, 1);
        wait_state(1, 3);
        write_gain(0, 3, 6'h11);
        wait_state(1, 6);
        write_gain(0, 1, 6'h2A);
        wait_state(0, 1);
        chk("ki_ch0_new", pid_ki, 6'h2A);
        chk("kp_ch0_sel3", pid_kp, CW'(KP0));
        chk("kd_ch0_sel3", pid_kd, CW'(KD0));

        // Capture of channel 1.
        wait_state(1, 10);
        pid_m_k = 12'h123;
        old_m0  = m_out[11:0];
        tick();
        chk("cap_m1", m_out[23:12], 12'h123);
        chk("cap_m0_kept", m_out[11:0], old_m0);
        chk("cap_upd", upd, 1);
        chk("cap_upd_ch", upd_ch, 1);
        chk("cap_frame_done", frame_done, 1);
        tick();
        chk("cap_upd_off", upd, 0);
        chk("cap_frame_done_off", frame_done, 0);

        // Channel 0 disabled.
        ch_en = 2'b10;
        err_in[23:0]  = 24'd100;
        err_in[47:24] = 24'hFFFFF9;
        #1;
        chk("dis_err0", pid_error, 0);
        wait_state(0, 10);
        pid_m_k = 12'h07F;
        tick();
        chk("dis_m0", m_out[11:0], 0);
        chk("dis_err1", pid_error, 24'hFFFFF9);
        wait_state(1, 10);
        pid_m_k = 12'h456;
        tick();
        chk("dis_m1", m_out[23:12], 12'h456);
        ch_en = 2'b11;

        // Reset mid-slot after programming KD.
        wait_state(0, 3);
        write_gain(1, 2, 6'h3E);
        wait_state(1, 5);
        chk("rst_kd_before", pid_kd, 6'h3E);
        reset = 1'b1;
        #1;
        chk("rst_pid_a", pid_a, 0);
        chk("rst_m_out", m_out, 0);
        chk("rst_kd", pid_kd, CW'(KD0));
        chk("rst_upd", upd, 0);
        @(posedge clk_pid);
        #1;
        @(posedge clk_pid);
        #1;
        release_seq();
        wait_state(1, 1);
        chk("rst_kd_ch1_cleared", pid_kd, CW'(KD0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
